// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared encodings for the pipeline hazard/control unit.
//   WB_DATA_ALU / WB_DATA_MEM : per-stage write-back data source
//   FWD_RF                    : forward select value meaning "use the register file"
//   STAGE_EXE/MEM/WB          : forward select values naming a downstream stage
package pipe_ctrl_pkg;

    typedef logic [2:0] fwd_sel_t;

    localparam logic WB_DATA_ALU = 1'b0;
    localparam logic WB_DATA_MEM = 1'b1;

    localparam fwd_sel_t FWD_RF    = 3'd0;
    localparam fwd_sel_t STAGE_EXE = 3'd1;
    localparam fwd_sel_t STAGE_MEM = 3'd2;
    localparam fwd_sel_t STAGE_WB  = 3'd3;

endpackage

// File: rtl/pipe_fwd_select.sv
// pipe_fwd_select
// Priority comparator for one ID-stage source operand.
// Ports:
//   used_i        operand is read by the ID instruction
//   addr_i        operand register address
//   regw_addr_i   packed write addresses, stage k at [k*REG_AW-1 -: REG_AW]
//   wb_wen_i      write enable per stage
//   wb_data_src_i write-back data source per stage (ALU / MEM)
//   sel_o         0 = register file, k = forward from stage k
//   ld_hit_o      the winning producer is a load still in EXE (data not ready)
module pipe_fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 3
) (
    input  logic                         used_i,
    input  logic [REG_AW-1:0]            addr_i,
    input  logic [FWD_STAGES*REG_AW-1:0] regw_addr_i,
    input  logic [FWD_STAGES-1:0]        wb_wen_i,
    input  logic [FWD_STAGES-1:0]        wb_data_src_i,
    output fwd_sel_t                     sel_o,
    output logic                         ld_hit_o
);

    fwd_sel_t win_stage_s;
    logic     win_src_s;

    // Youngest matching producer wins: scan oldest to youngest so the lowest stage overwrites.
    always_comb begin
        win_stage_s = FWD_RF;
        win_src_s   = WB_DATA_ALU;
        if (used_i && (addr_i != {REG_AW{1'b0}})) begin
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (wb_wen_i[k-1] && (regw_addr_i[k*REG_AW-1 -: REG_AW] == addr_i)) begin
                    win_stage_s = fwd_sel_t'(k);
                    win_src_s   = wb_data_src_i[k-1];
                end else begin
                    win_src_s   = win_src_s;
                end
            end
        end else begin
            win_stage_s = FWD_RF;
            win_src_s   = WB_DATA_ALU;
        end
    end

    // A load in EXE has no data yet, so it blocks forwarding from older stages too.
    always_comb begin
        ld_hit_o = (win_stage_s == STAGE_EXE) && (win_src_s == WB_DATA_MEM);
        if (ld_hit_o) begin
            sel_o = FWD_RF;
        end else begin
            sel_o = win_stage_s;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
// Hazard detection and stage control for the pipelined MIPS core.
// Produces operand forward selects, load-use and HI/LO stalls, branch
// flushes and the IF/ID/EXE/MEM/WB enable/reset controls. All outputs are
// combinational from the inputs and the two internal busy counters.
// Ports:
//   clk, rst (async, active-high)
//   rs_used/rt_used, addr_rs/addr_rt, is_store : ID operand usage
//   regw_addr, wb_wen, wb_data_src             : per downstream stage write-back state
//   md_start, md_read, branch_taken            : mul/div issue, HI/LO read, taken branch
//   fwd_a_sel, fwd_b_sel, fwd_m                : forwarding controls
//   load_stall, md_stall, flush                : status
//   *_rst, *_en                                : per stage controls
// Optional feature macro PIPE_DEBUG_STEP_EN adds debug_en/debug_step single-step hold.
module pipe_hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FWD_STAGES   = 3,
    parameter int MD_LATENCY   = 4,
    parameter int BRANCH_FLUSH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef PIPE_DEBUG_STEP_EN
    input  logic                         debug_en,
    input  logic                         debug_step,
`endif
    input  logic                         rs_used,
    input  logic                         rt_used,
    input  logic [REG_AW-1:0]            addr_rs,
    input  logic [REG_AW-1:0]            addr_rt,
    input  logic                         is_store,
    input  logic [FWD_STAGES*REG_AW-1:0] regw_addr,
    input  logic [FWD_STAGES-1:0]        wb_wen,
    input  logic [FWD_STAGES-1:0]        wb_data_src,
    input  logic                         md_start,
    input  logic                         md_read,
    input  logic                         branch_taken,
    output logic [2:0]                   fwd_a_sel,
    output logic [2:0]                   fwd_b_sel,
    output logic                         fwd_m,
    output logic                         load_stall,
    output logic                         md_stall,
    output logic                         flush,
    output logic                         if_rst,
    output logic                         if_en,
    output logic                         id_rst,
    output logic                         id_en,
    output logic                         exe_rst,
    output logic                         exe_en,
    output logic                         mem_rst,
    output logic                         mem_en,
    output logic                         wb_rst,
    output logic                         wb_en
);

    localparam int MD_CW = $clog2(MD_LATENCY + 1);
    localparam int FL_CW = $clog2(BRANCH_FLUSH + 1);
    localparam logic [MD_CW-1:0] MD_LOAD = MD_CW'(MD_LATENCY);
    localparam logic [FL_CW-1:0] FL_LOAD = FL_CW'(BRANCH_FLUSH - 1);

    fwd_sel_t         a_sel_s, b_sel_s;
    logic             a_ld_s, b_ld_s;
    logic             flush_s, ld_stall_s, md_stall_s, hold_s, md_accept_s;
    logic [MD_CW-1:0] md_cnt_q, md_cnt_d;
    logic [FL_CW-1:0] fl_cnt_q, fl_cnt_d;

    pipe_fwd_select #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES)) u_fwd_rs (
        .used_i(rs_used), .addr_i(addr_rs), .regw_addr_i(regw_addr),
        .wb_wen_i(wb_wen), .wb_data_src_i(wb_data_src), .sel_o(a_sel_s), .ld_hit_o(a_ld_s)
    );

    pipe_fwd_select #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES)) u_fwd_rt (
        .used_i(rt_used), .addr_i(addr_rt), .regw_addr_i(regw_addr),
        .wb_wen_i(wb_wen), .wb_data_src_i(wb_data_src), .sel_o(b_sel_s), .ld_hit_o(b_ld_s)
    );

`ifdef PIPE_DEBUG_STEP_EN
    logic step_q;

    // Previous debug_step level, for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= debug_step;
        end
    end

    assign hold_s = debug_en & ~(debug_step & ~step_q);
`else
    assign hold_s = 1'b0;
`endif

    // Raw hazard conditions and status outputs (forced quiet while in reset).
    always_comb begin
        flush_s    = branch_taken | (fl_cnt_q != {FL_CW{1'b0}});
        // A store reading a loaded value through rt takes it from MEM instead of stalling.
        ld_stall_s = a_ld_s | (b_ld_s & ~is_store);
        md_stall_s = (md_cnt_q != {MD_CW{1'b0}}) & (md_read | md_start);
        if (rst) begin
            fwd_a_sel  = FWD_RF;
            fwd_b_sel  = FWD_RF;
            fwd_m      = 1'b0;
            load_stall = 1'b0;
            md_stall   = 1'b0;
            flush      = 1'b0;
        end else begin
            fwd_a_sel  = a_sel_s;
            fwd_b_sel  = b_sel_s;
            fwd_m      = b_ld_s & is_store;
            load_stall = ld_stall_s;
            md_stall   = md_stall_s;
            flush      = flush_s;
        end
    end

    // Stage enables/resets by priority: reset, debug hold, flush, stall, run.
    always_comb begin
        if_rst  = 1'b0; id_rst  = 1'b0; exe_rst = 1'b0; mem_rst = 1'b0; wb_rst = 1'b0;
        if_en   = 1'b1; id_en   = 1'b1; exe_en  = 1'b1; mem_en  = 1'b1; wb_en  = 1'b1;
        if (rst) begin
            if_rst  = 1'b1; id_rst  = 1'b1; exe_rst = 1'b1; mem_rst = 1'b1; wb_rst = 1'b1;
        end else if (hold_s) begin
            if_en   = 1'b0; id_en   = 1'b0; exe_en  = 1'b0; mem_en  = 1'b0; wb_en  = 1'b0;
        end else if (flush_s) begin
            // ID holds a wrong-path instruction, so any stall it would raise is moot.
            id_rst  = 1'b1;
        end else if (ld_stall_s | md_stall_s) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_rst = 1'b1;
        end else begin
            if_en   = 1'b1;
            id_en   = 1'b1;
        end
    end

    // Next values of the mul/div and branch-flush busy counters.
    always_comb begin
        md_accept_s = md_start & id_en & ~flush_s;
        if (hold_s) begin
            md_cnt_d = md_cnt_q;
        end else if (md_accept_s) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != {MD_CW{1'b0}}) begin
            md_cnt_d = md_cnt_q - MD_CW'(1);
        end else begin
            md_cnt_d = md_cnt_q;
        end
        if (hold_s) begin
            fl_cnt_d = fl_cnt_q;
        end else if (branch_taken) begin
            fl_cnt_d = FL_LOAD;
        end else if (fl_cnt_q != {FL_CW{1'b0}}) begin
            fl_cnt_d = fl_cnt_q - FL_CW'(1);
        end else begin
            fl_cnt_d = fl_cnt_q;
        end
    end

    // Busy counter registers; reset clears any pending stall or flush at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_q <= {MD_CW{1'b0}};
            fl_cnt_q <= {FL_CW{1'b0}};
        end else begin
            md_cnt_q <= md_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

endmodule
